proj_sorter_topk: RTL and testbench

//  Streaming bottom-K MinHash selector and successor to the single-set sorter.

---
 rtl/proj_sorter_topk.sv | 89 ++++++++
 tb/tb_proj_sorter_topk.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/proj_sorter_topk.sv
// proj_sorter_topk: streaming bottom-K MinHash selector keeping the K smallest {sig, idx} keys in order
//   Ports: clk, rst_n (async active-low), clear (sync flush, highest priority)
//          in_valid/in_ready/in_signature/in_index/in_last : pair stream from the hasher
//          out_valid/out_ready                             : held handshake to the extender
//          out_smallest_idx/out_smallest_sig [0]=smallest  : retained table, unused slots sig='1 idx=0
//          out_count (valid entries), out_total (accepted pairs, saturating)
module proj_sorter_topk #(
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 6,
    parameter int SIGNATURE_LEN = 32,
    parameter int CNT_LEN       = 16,
    parameter bit DEDUP_EN      = 1'b1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         clear,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [SIGNATURE_LEN-1:0]                     in_signature,
    input  logic [INDICE_LEN-1:0]                        in_index,
    input  logic                                         in_last,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]     out_smallest_idx,
    output logic [INDICES_COUNT-1:0][SIGNATURE_LEN-1:0]  out_smallest_sig,
    output logic [$clog2(INDICES_COUNT+1)-1:0]           out_count,
    output logic [CNT_LEN-1:0]                           out_total
);
    localparam int K  = INDICES_COUNT;
    localparam int CW = $clog2(K + 1);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;
    logic [0:0]                        state;
    logic [K-1:0][SIGNATURE_LEN-1:0]   sig_q, sig_sh, sig_d;
    logic [K-1:0][INDICE_LEN-1:0]      idx_q, idx_sh, idx_d;
    logic [CW-1:0]                     count_q;
    logic [CNT_LEN-1:0]                total_q;
    logic [K-1:0]                      gt, first;
    logic                              dup, accept, ins, flush;
    assign in_ready         = state == COLLECT;
    assign out_valid        = state == HOLD;
    assign out_smallest_idx = idx_q;
    assign out_smallest_sig = sig_q;
    assign out_count        = count_q;
    assign out_total        = total_q;
    assign accept = in_valid && in_ready && !clear;
    assign flush  = clear || (out_valid && out_ready);
    // gt[i]: slot i ranks after the new pair; invalid slots always do. The table
    // is sorted so gt is thermometer-shaped and first marks the insertion slot.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < K; i++) begin
            gt[i] = i >= int'(count_q) || sig_q[i] > in_signature ||
                    (sig_q[i] == in_signature && idx_q[i] > in_index);
            dup = dup || (i < int'(count_q) && sig_q[i] == in_signature);
        end
        first  = gt & ~(gt << 1);
        sig_sh = sig_q << SIGNATURE_LEN;
        idx_sh = idx_q << INDICE_LEN;
        ins    = accept && gt[K-1] && !(DEDUP_EN && dup);
        for (int i = 0; i < K; i++) begin
            sig_d[i] = first[i] ? in_signature : gt[i] ? sig_sh[i] : sig_q[i];
            idx_d[i] = first[i] ? in_index : gt[i] ? idx_sh[i] : idx_q[i];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            sig_q   <= '1;
            idx_q   <= '0;
            count_q <= '0;
            total_q <= '0;
        end else if (flush) begin
            state   <= COLLECT;
            sig_q   <= '1;
            idx_q   <= '0;
            count_q <= '0;
            total_q <= '0;
        end else if (accept) begin
            if (ins) begin
                sig_q   <= sig_d;
                idx_q   <= idx_d;
                count_q <= count_q + CW'(count_q != CW'(K));
            end
            total_q <= total_q + CNT_LEN'(~&total_q);
            state   <= in_last ? HOLD : COLLECT;
        end
    end
endmodule

// File: tb/tb_proj_sorter_topk.sv
// tb_proj_sorter_topk: checks proj_sorter_topk with and without dedup against tables and a queue model
module tb_proj_sorter_topk;
    localparam int K = 4;
    localparam logic [31:0] F = 32'hFFFFFFFF;
    typedef struct { logic [31:0] s; logic [5:0] i; } ent_t;
    typedef struct {
        int n;
        logic [31:0] s [6];
        logic [5:0]  i [6];
        int          c [2];
        logic [31:0] es [2][4];
        logic [5:0]  ei [2][4];
    } vec_t;
    logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic [31:0] in_signature = 0;
    logic [5:0]  in_index = 0;
    logic                 o_rdy [2], o_valid [2];
    logic [K-1:0][5:0]    o_idx [2];
    logic [K-1:0][31:0]   o_sig [2];
    logic [2:0]           o_cnt [2];
    logic [15:0]          o_tot [2];
    ent_t mq [2][$];
    int tot = 0, errors = 0, checks = 0;
    vec_t vt [3];
    always #5 clk = ~clk;
    proj_sorter_topk #(.DEDUP_EN(1'b0)) d0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(o_rdy[0]),
        .in_signature(in_signature), .in_index(in_index), .in_last(in_last),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_smallest_idx(o_idx[0]),
        .out_smallest_sig(o_sig[0]), .out_count(o_cnt[0]), .out_total(o_tot[0]));
    proj_sorter_topk #(.DEDUP_EN(1'b1)) d1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(o_rdy[1]),
        .in_signature(in_signature), .in_index(in_index), .in_last(in_last),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_smallest_idx(o_idx[1]),
        .out_smallest_sig(o_sig[1]), .out_count(o_cnt[1]), .out_total(o_tot[1]));
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic mreset();
        tot = 0;
        mq[0].delete();
        mq[1].delete();
    endtask
    // Reference: sorted queue by {sig,idx}, truncated to K; dedup variant skips held sigs.
    task automatic model_push(input logic [31:0] s, input logic [5:0] ix);
        ent_t e;
        bit dp;
        int p;
        e.s = s;
        e.i = ix;
        tot++;
        for (int d = 0; d < 2; d++) begin
            dp = 0;
            for (int j = 0; j < mq[d].size(); j++) if (mq[d][j].s == s) dp = 1;
            if (!(d == 1 && dp)) begin
                p = mq[d].size();
                for (int j = mq[d].size() - 1; j >= 0; j--)
                    if ({mq[d][j].s, mq[d][j].i} > {s, ix}) p = j;
                mq[d].insert(p, e);
                if (mq[d].size() > K) void'(mq[d].pop_back());
            end
        end
    endtask
    task automatic send(input logic [31:0] s, input logic [5:0] ix, input bit last);
        in_valid = 1;
        in_signature = s;
        in_index = ix;
        in_last = last;
        @(posedge clk); #1;
        in_valid = 0;
        in_last = 0;
        model_push(s, ix);
    endtask
    task automatic check_set(input string n);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d valid", n, d), 64'(o_valid[d]), 1);
            chk($sformatf("%s d%0d in_ready", n, d), 64'(o_rdy[d]), 0);
            chk($sformatf("%s d%0d count", n, d), 64'(o_cnt[d]), 64'(mq[d].size()));
            chk($sformatf("%s d%0d total", n, d), 64'(o_tot[d]), 64'(tot));
            for (int j = 0; j < K; j++) begin
                chk($sformatf("%s d%0d sig%0d", n, d, j), 64'(o_sig[d][j]),
                    64'(j < mq[d].size() ? mq[d][j].s : F));
                chk($sformatf("%s d%0d idx%0d", n, d, j), 64'(o_idx[d][j]),
                    64'(j < mq[d].size() ? mq[d][j].i : 6'd0));
            end
        end
    endtask
    task automatic check_empty(input string n);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d valid", n, d), 64'(o_valid[d]), 0);
            chk($sformatf("%s d%0d in_ready", n, d), 64'(o_rdy[d]), 1);
            chk($sformatf("%s d%0d count", n, d), 64'(o_cnt[d]), 0);
            chk($sformatf("%s d%0d total", n, d), 64'(o_tot[d]), 0);
            chk($sformatf("%s d%0d sig0", n, d), 64'(o_sig[d][0]), 64'(F));
            chk($sformatf("%s d%0d idx0", n, d), 64'(o_idx[d][0]), 0);
        end
    endtask
    task automatic handshake(input string n);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check_empty(n);
        mreset();
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
    initial begin
        vt[0] = '{5, '{9, 3, 7, 1, 5, 0}, '{0, 1, 2, 3, 4, 0}, '{4, 4},
                  '{'{1, 3, 5, 7}, '{1, 3, 5, 7}}, '{'{3, 1, 4, 2}, '{3, 1, 4, 2}}};
        vt[1] = '{3, '{5, 5, 5, 0, 0, 0}, '{2, 1, 3, 0, 0, 0}, '{3, 1},
                  '{'{5, 5, 5, F}, '{5, F, F, F}}, '{'{1, 2, 3, 0}, '{2, 0, 0, 0}}};
        vt[2] = '{4, '{4, 4, 2, 4, 0, 0}, '{0, 1, 2, 3, 0, 0}, '{4, 2},
                  '{'{2, 4, 4, 4}, '{2, 4, F, F}}, '{'{2, 0, 1, 3}, '{2, 0, 0, 0}}};
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        check_empty("reset");
        for (int v = 0; v < 3; v++) begin
            mreset();
            for (int p = 0; p < vt[v].n; p++) send(vt[v].s[p], vt[v].i[p], p == vt[v].n - 1);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("T%0d d%0d valid", v + 1, d), 64'(o_valid[d]), 1);
                chk($sformatf("T%0d d%0d count", v + 1, d), 64'(o_cnt[d]), 64'(vt[v].c[d]));
                chk($sformatf("T%0d d%0d total", v + 1, d), 64'(o_tot[d]), 64'(vt[v].n));
                for (int j = 0; j < K; j++) begin
                    chk($sformatf("T%0d d%0d sig%0d", v + 1, d, j), 64'(o_sig[d][j]), 64'(vt[v].es[d][j]));
                    chk($sformatf("T%0d d%0d idx%0d", v + 1, d, j), 64'(o_idx[d][j]), 64'(vt[v].ei[d][j]));
                end
            end
            handshake($sformatf("T%0d release", v + 1));
        end
        // backpressure: set held while a pair is offered and out_ready stays low
        send(8, 1, 0);
        send(2, 2, 0);
        send(6, 3, 1);
        in_valid = 1;
        in_signature = 0;
        in_index = 9;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check_set($sformatf("T4 hold%0d", c));
        end
        in_valid = 0;
        handshake("T4 release");
        send(3, 4, 0);
        send(1, 5, 1);
        check_set("T4 next");
        handshake("T4 next release");
        // clear mid-set with a pair offered in the same cycle
        send(1, 1, 0);
        send(2, 2, 0);
        send(3, 3, 0);
        clear = 1;
        in_valid = 1;
        in_signature = 0;
        in_index = 9;
        @(posedge clk); #1;
        clear = 0;
        in_valid = 0;
        mreset();
        check_empty("T5 clear");
        send(F, 7, 1);
        check_set("T5 clear newset");
        // clear while holding a set
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        mreset();
        check_empty("clear in hold");
        // async reset mid-set
        send(1, 1, 0);
        send(2, 2, 0);
        send(3, 3, 0);
        rst_n = 0;
        #2;
        check_empty("T5 rst");
        #1 rst_n = 1;
        mreset();
        @(posedge clk); #1;
        send(F, 7, 1);
        check_set("T5 rst newset");
        handshake("T5 release");
        // randomized sets with gaps, ties, duplicates and all-ones signatures
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int p = 0; p < n; p++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send($urandom_range(0, 5) == 0 ? F : 32'($urandom_range(0, 9)),
                     6'($urandom_range(0, 63)), p == n - 1);
            end
            check_set($sformatf("rand%0d", r));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            check_set($sformatf("rand%0d held", r));
            handshake($sformatf("rand%0d release", r));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
